// File: rtl/audio_pkg.sv
// Shared widths, clock-tap positions, the frame payload struct and the saturating gain helper
// used by the I2S transmitter.
package audio_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned WORD_W     = 2 * DATA_W;
    localparam int unsigned CNT_W      = 9;
    localparam int unsigned FRAME_CLKS = 512;
    localparam int unsigned MCLK_BIT   = 1;
    localparam int unsigned SCK_BIT    = 3;
    localparam int unsigned LRCK_BIT   = 8;
    localparam int unsigned SLOT_LSB   = 4;

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } frame_t;

    // Arithmetic left shift by 0..3 with clamping to the signed 16-bit range.
    function automatic logic [DATA_W-1:0] sat16(input logic [DATA_W-1:0] x, input logic [1:0] sh);
        localparam logic signed [DATA_W+2:0] SAT_MAX = 19'sd32767;
        localparam logic signed [DATA_W+2:0] SAT_MIN = -19'sd32768;
        logic signed [DATA_W+2:0] w;
        w = $signed({{3{x[DATA_W-1]}}, x}) <<< sh;
        if (w > SAT_MAX) begin
            return 16'h7FFF;
        end else if (w < SAT_MIN) begin
            return 16'h8000;
        end
        return w[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Sample-in / I2S-out bundle between the note generator, the transmitter and the DAC pins.
// The gain field exists only when I2S_GAIN_EN is defined.
interface i2s_audio_tx_if;
    logic [audio_pkg::DATA_W-1:0] audio_left;
    logic [audio_pkg::DATA_W-1:0] audio_right;
`ifdef I2S_GAIN_EN
    logic [1:0]                   gain;
`endif
    logic                         sample_req;
    logic                         audio_mclk;
    logic                         audio_lrck;
    logic                         audio_sck;
    logic                         audio_sdin;

    modport master (
`ifdef I2S_GAIN_EN
        output gain,
`endif
        output audio_left, audio_right,
        input  sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );

    modport slave (
`ifdef I2S_GAIN_EN
        input  gain,
`endif
        input  audio_left, audio_right,
        output sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/i2s_clk_div.sv
// Free-running frame counter; MCLK/SCK/LRCK are taps of the counter flops and
// sample_req is registered so it is high exactly while the counter reads zero.
module i2s_clk_div
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             mclk,
    output logic             sck,
    output logic             lrck,
    output logic             sample_req
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            sample_req <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            sample_req <= (cnt_q == CNT_W'(FRAME_CLKS - 1));
        end
    end

    assign cnt  = cnt_q;
    assign mclk = cnt_q[MCLK_BIT];
    assign sck  = cnt_q[SCK_BIT];
    assign lrck = cnt_q[LRCK_BIT];

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-I2S serialiser for the Pmod DAC: captures L/R once per 512-clk frame and shifts
// them out MSB-first with the one-bit delay. Optional gain stage: define I2S_GAIN_EN.
module i2s_audio_tx
    import audio_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    i2s_audio_tx_if.slave bus
);

    logic [CNT_W-1:0]  cnt;
    logic              mclk;
    logic              sck;
    logic              lrck;
    logic              req;
    logic              frame_end_c;
    logic              bit_end_c;
    frame_t            frame_in_c;
    logic [WORD_W-1:0] shift_q;
    logic              sdin_q;

    i2s_clk_div u_clk_div (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .mclk       (mclk),
        .sck        (sck),
        .lrck       (lrck),
        .sample_req (req)
    );

    always_comb begin
`ifdef I2S_GAIN_EN
        frame_in_c.left  = sat16(bus.audio_left,  bus.gain);
        frame_in_c.right = sat16(bus.audio_right, bus.gain);
`else
        frame_in_c.left  = bus.audio_left;
        frame_in_c.right = bus.audio_right;
`endif
    end

    assign frame_end_c = (cnt == CNT_W'(FRAME_CLKS - 1));
    assign bit_end_c   = &cnt[SLOT_LSB-1:0];

    // After 31 shifts the old R[0] sits at the MSB, so slot 0 takes it while the new word loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            sdin_q  <= 1'b0;
        end else if (frame_end_c) begin
            sdin_q  <= shift_q[WORD_W-1];
            shift_q <= frame_in_c;
        end else if (bit_end_c) begin
            sdin_q  <= shift_q[WORD_W-1];
            shift_q <= {shift_q[WORD_W-2:0], 1'b0};
        end
    end

    assign bus.sample_req = req;
    assign bus.audio_mclk = mclk;
    assign bus.audio_sck  = sck;
    assign bus.audio_lrck = lrck;
    assign bus.audio_sdin = sdin_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: reset, clock ratios, frame decode, mid-frame changes,
// mid-frame reset and (with I2S_GAIN_EN) gain saturation.
module tb_i2s_audio_tx;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;

    always #5 clk = ~clk;

    i2s_audio_tx_if bus();

    i2s_audio_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while ((n % 512) != c && guard < 1024) begin
            tick();
            guard++;
        end
    endtask

    // Starts at cnt 8 of a frame; samples mid-SCK-high of slots 1..31 and next slot 0.
    task automatic decode_frame(input int chg_at, input logic [15:0] chg_l,
                                output logic [31:0] w, output int unstable);
        logic held;
        int   slot;
        w = '0;
        unstable = 0;
        held = 1'b0;
        goto(8);
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (8 + i == chg_at) bus.audio_left = chg_l;
            if (i % 16 == 0) begin
                slot = i / 16;
                held = bus.audio_sdin;
                if (slot <= 31) w[32 - slot] = held;
                else            w[0] = held;
            end else if (i % 16 == 7 && i > 16) begin
                if (bus.audio_sdin !== held) unstable++;
            end
        end
    endtask

    task automatic test_reset();
        int first;
        int pulses;
        rst = 1'b0;
        bus.audio_left  = '0;
        bus.audio_right = '0;
`ifdef I2S_GAIN_EN
        bus.gain = 2'd0;
`endif
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.audio_mclk !== 1'b0) begin errors++; $display("FAIL reset_mclk got %b want 0", bus.audio_mclk); end
        checks++; if (bus.audio_sck  !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", bus.audio_sck); end
        checks++; if (bus.audio_lrck !== 1'b0) begin errors++; $display("FAIL reset_lrck got %b want 0", bus.audio_lrck); end
        checks++; if (bus.audio_sdin !== 1'b0) begin errors++; $display("FAIL reset_sdin got %b want 0", bus.audio_sdin); end
        checks++; if (bus.sample_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.sample_req); end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        first = -1;
        pulses = 0;
        for (int i = 0; i < 520; i++) begin
            tick();
            if (bus.sample_req === 1'b1) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        checks++; if (first !== 512) begin errors++; $display("FAIL first_req got %0d want 512", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL req_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_clock_ratios();
        int mclk_tog = 0, sck_fall = 0, lrck_tog = 0, misalign = 0, phase_bad = 0;
        logic pm, ps, pl;
        logic [8:0] c;
        pm = bus.audio_mclk; ps = bus.audio_sck; pl = bus.audio_lrck;
        for (int i = 0; i < 1024; i++) begin
            tick();
            c = 9'(n % 512);
            if (bus.audio_mclk !== pm) mclk_tog++;
            if (ps === 1'b1 && bus.audio_sck === 1'b0) sck_fall++;
            if (bus.audio_lrck !== pl) begin
                lrck_tog++;
                if (!(ps === 1'b1 && bus.audio_sck === 1'b0)) misalign++;
            end
            if (bus.audio_mclk !== c[1] || bus.audio_sck !== c[3] || bus.audio_lrck !== c[8]) phase_bad++;
            pm = bus.audio_mclk; ps = bus.audio_sck; pl = bus.audio_lrck;
        end
        checks++; if (mclk_tog !== 512) begin errors++; $display("FAIL mclk_toggles got %0d want 512", mclk_tog); end
        checks++; if (sck_fall !== 64) begin errors++; $display("FAIL sck_periods got %0d want 64", sck_fall); end
        checks++; if (lrck_tog !== 4) begin errors++; $display("FAIL lrck_toggles got %0d want 4", lrck_tog); end
        checks++; if (misalign !== 0) begin errors++; $display("FAIL lrck_align got %0d want 0", misalign); end
        checks++; if (phase_bad !== 0) begin errors++; $display("FAIL clk_phase got %0d want 0", phase_bad); end
    endtask

    task automatic test_data();
        logic [31:0] w;
        int unstable;
        bus.audio_left = 16'hA5A5; bus.audio_right = 16'h3C0F;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'hA5A5_3C0F) begin errors++; $display("FAIL frame_a5a5 got %h want a5a53c0f", w); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL sdin_stable got %0d want 0", unstable); end
        bus.audio_left = 16'h8001; bus.audio_right = 16'h7FFE;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'h8001_7FFE) begin errors++; $display("FAIL frame_8001 got %h want 80017ffe", w); end
    endtask

    task automatic test_mid_frame_change();
        logic [31:0] w;
        int unstable;
        bus.audio_left = 16'h1234; bus.audio_right = 16'h5678;
        tick(); goto(0);
        decode_frame(100, 16'h0000, w, unstable);
        checks++; if (w !== 32'h1234_5678) begin errors++; $display("FAIL mid_cur got %h want 12345678", w); end
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'h0000_5678) begin errors++; $display("FAIL mid_next got %h want 00005678", w); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        int unstable;
        goto(300);
        rst = 1'b0;
        #1;
        checks++; if (bus.audio_mclk !== 1'b0) begin errors++; $display("FAIL rmid_mclk got %b want 0", bus.audio_mclk); end
        checks++; if (bus.audio_sck  !== 1'b0) begin errors++; $display("FAIL rmid_sck got %b want 0", bus.audio_sck); end
        checks++; if (bus.audio_lrck !== 1'b0) begin errors++; $display("FAIL rmid_lrck got %b want 0", bus.audio_lrck); end
        checks++; if (bus.audio_sdin !== 1'b0) begin errors++; $display("FAIL rmid_sdin got %b want 0", bus.audio_sdin); end
        checks++; if (bus.sample_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", bus.sample_req); end
        bus.audio_left = 16'hCAFE; bus.audio_right = 16'h0F0F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'hCAFE_0F0F) begin errors++; $display("FAIL after_reset got %h want cafe0f0f", w); end
    endtask

`ifdef I2S_GAIN_EN
    task automatic test_gain();
        logic [31:0] w;
        int unstable;
        bus.gain = 2'd1; bus.audio_left = 16'h5000; bus.audio_right = 16'hB000;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'h7FFF_8000) begin errors++; $display("FAIL gain1_sat got %h want 7fff8000", w); end
        bus.gain = 2'd3; bus.audio_left = 16'h0FFF; bus.audio_right = 16'hFFFF;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'h7FF8_FFF8) begin errors++; $display("FAIL gain3 got %h want 7ff8fff8", w); end
        bus.gain = 2'd0; bus.audio_left = 16'h5000; bus.audio_right = 16'hB000;
        tick(); goto(0);
        decode_frame(-1, 16'h0000, w, unstable);
        checks++; if (w !== 32'h5000_B000) begin errors++; $display("FAIL gain0 got %h want 5000b000", w); end
    endtask
`endif

    initial begin
        test_reset();
        test_clock_ratios();
        test_data();
        test_mid_frame_change();
        test_reset_mid_frame();
`ifdef I2S_GAIN_EN
        test_gain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
